// File: rtl/lo_phase_sequencer_if.sv
// Bus between the LO phase sequencer and its controller: control inputs,
// the registered phase code/index outputs, and a prescaler debug view.
interface lo_phase_sequencer_if #(
    parameter int DIVW = 8
) ();
    // Control inputs are sampled on every rising clk edge. There is no
    // valid/ready: load is a single-cycle request, always taken that edge.
    logic            en;
    logic            dir;
    logic [DIVW-1:0] div;
    logic            load;
    logic [4:0]      load_idx;
    logic [5:0]      code;
    logic [4:0]      idx;
    logic            wrap;
    logic            load_err;
    logic [DIVW-1:0] presc;

    modport master (
        output en, dir, div, load, load_idx,
        input  code, idx, wrap, load_err, presc
    );

    modport slave (
        input  en, dir, div, load, load_idx,
        output code, idx, wrap, load_err, presc
    );
endinterface

// File: rtl/lo_phase_sequencer.sv
// Steps a registered 6-bit LO phase code through a fixed 20-entry table at a
// programmable rate, forward or reverse, with synchronous phase load.
module lo_phase_sequencer #(
    parameter int NPH  = 20,
    parameter int DIVW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lo_phase_sequencer_if.slave  bus
);
    localparam logic [4:0] LAST_IDX = 5'(NPH - 1);

    logic [DIVW-1:0] r_presc;
    logic [4:0]      r_idx;
    logic [5:0]      r_code;
    logic            r_wrap;
    logic            r_load_err;

    logic            w_load_ok;
    logic            w_load_bad;
    logic            w_due;
    logic            w_step;
    logic            w_wrap_next;
    logic [4:0]      w_next_idx;

    function automatic logic [5:0] code_of(input logic [4:0] i);
        logic [5:0] c;
        case (i)
            5'd0:    c = 6'h03;
            5'd1:    c = 6'h02;
            5'd2:    c = 6'h06;
            5'd3:    c = 6'h0D;
            5'd4:    c = 6'h0F;
            5'd5:    c = 6'h0B;
            5'd6:    c = 6'h19;
            5'd7:    c = 6'h1F;
            5'd8:    c = 6'h1C;
            5'd9:    c = 6'h10;
            5'd10:   c = 6'h30;
            5'd11:   c = 6'h3C;
            5'd12:   c = 6'h3F;
            5'd13:   c = 6'h39;
            5'd14:   c = 6'h2B;
            5'd15:   c = 6'h2F;
            5'd16:   c = 6'h2D;
            5'd17:   c = 6'h26;
            5'd18:   c = 6'h22;
            5'd19:   c = 6'h23;
            default: c = 6'h03;
        endcase
        return c;
    endfunction

    always_comb begin
        w_load_ok   = bus.load && (bus.load_idx <= LAST_IDX);
        w_load_bad  = bus.load && (bus.load_idx > LAST_IDX);
        // >= rather than == so lowering div below presc steps at once.
        w_due       = bus.en && (r_presc >= bus.div);
        w_step      = w_due && !bus.load;
        w_next_idx  = r_idx;
        w_wrap_next = 1'b0;
        if (bus.dir) begin
            w_next_idx  = (r_idx == LAST_IDX) ? 5'd0 : r_idx + 5'd1;
            w_wrap_next = (r_idx == LAST_IDX);
        end else begin
            w_next_idx  = (r_idx == 5'd0) ? LAST_IDX : r_idx - 5'd1;
            w_wrap_next = (r_idx == 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_idx      <= 5'd0;
            r_code     <= 6'h03;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_idx   <= bus.load_idx;
                r_code  <= code_of(bus.load_idx);
                r_presc <= '0;
            end else if (w_load_bad) begin
                // Rejected load freezes everything, including a due step.
                r_presc <= r_presc;
            end else if (bus.en) begin
                if (w_step) begin
                    r_presc <= '0;
                    r_idx   <= w_next_idx;
                    r_code  <= code_of(w_next_idx);
                    r_wrap  <= w_wrap_next;
                end else begin
                    r_presc <= r_presc + DIVW'(1);
                end
            end
        end
    end

    assign bus.code     = r_code;
    assign bus.idx      = r_idx;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_load_err;
    assign bus.presc    = r_presc;
endmodule

// File: doc/lo_phase_sequencer.md
# lo_phase_sequencer

- Generates the 6-bit LO phase code consumed by the downstream 20-phase LO phase decoder.
- Steps through a fixed 20-entry code sequence at a programmable rate, forward or reverse, with synchronous phase load.
- The code is registered, so the decoder sees one clean transition per step.

## Interface
Parameters:
- NPH, 20, number of phases; fixed, the code table below has exactly 20 entries
- DIVW, 8, width of the step-period divider

Ports:
- clk  input  1  single clock; all state is on its rising edge
- rst_n  input  1  reset, asynchronous, active-low; deassertion is synchronous to clk upstream
- en  input  1  step enable; when low, the prescaler and phase hold
- dir  input  1  1 = forward (index +1), 0 = reverse (index -1)
- div  input  DIVW  step period minus 1; a step occurs every div+1 enabled cycles
- load  input  1  single-cycle synchronous phase load request
- load_idx  input  5  phase index to load (0..19)
- code  output  6  registered phase code to the decoder
- idx  output  5  registered current phase index (0..19)
- wrap  output  1  one-cycle pulse on sequence wrap
- load_err  output  1  one-cycle pulse when load_idx > 19

## Operation
Code table, index 0..19, in hex:
- 03, 02, 06, 0D, 0F, 0B, 19, 1F, 1C, 10
- 30, 3C, 3F, 39, 2B, 2F, 2D, 26, 22, 23

Invariants:
- code always equals table[idx].
- No other 6-bit value ever appears on code, including at reset.

Prescaler (presc, DIVW bits):
- When en=1 and presc >= div, a step occurs and presc clears to 0.
- When en=1 and presc < div, presc increments.
- When en=0, presc holds.
- The >= compare means lowering div below the current presc causes a step on the next enabled cycle, never a long stall.

Step:
- Forward: idx becomes (idx+1) mod 20; 19 goes to 0.
- Reverse: idx becomes (idx-1) mod 20; 0 goes to 19.
- code is updated in the same clock edge from the next-index table lookup. code is never one cycle behind idx.

Wrap:
- wrap pulses high for the single cycle after a step from 19 to 0 (forward) or from 0 to 19 (reverse).
- Otherwise wrap is 0.

Load has priority over step:
- When load=1 and load_idx <= 19: idx becomes load_idx, code becomes table[load_idx], presc clears to 0, and no wrap is generated.
- When load=1 and load_idx > 19: idx, code and presc are unchanged, any step due that cycle is suppressed, and load_err pulses for one cycle.

Changes to dir take effect on the next step. No state is flushed.

## Timing
Reset values while rst_n=0:
- idx = 0, code = 6'h03, presc = 0, wrap = 0, load_err = 0.
- Reset is asynchronous and takes effect immediately, including mid-step or mid-load.

Latency:
- load to code/idx: 1 cycle.
- After reset release with en=1 and div=D, the first step lands on the edge ending the (D+1)th enabled cycle.
- With div=0 and en=1, the phase advances every cycle.

Output timing:
- All outputs are registered with no combinational path from inputs.
- wrap and load_err never assert in the same cycle.

en dropping:
- If en drops on the cycle a step would occur, no step occurs.
- presc then holds at its value (>= div), so the step fires on the first cycle en returns.

## Test plan
- Reset: assert rst_n=0 mid-count at idx=7 -> code=03, idx=0, wrap=0, load_err=0 immediately, without waiting for a clock edge.
- Forward full cycle, div=0, dir=1, en=1: over 20 cycles code reads 02,06,0D,...,22,23,03. wrap is high only in the cycle code returns to 03. No out-of-table value is seen.
- Divider, div=2, dir=1: code changes exactly every 3 cycles. Dropping en for 5 cycles delays the next change by 5 cycles. Changing div from 9 to 1 when presc=6 -> step on the next cycle.
- Reverse from load, dir=0, div=0: load load_idx=1 -> code=02 the next cycle, then 03, then 23 with wrap pulsing, then 22.
- Load priority: load load_idx=7 in the same cycle a step is due -> code=1F, idx=7, presc=0, no wrap. The next step occurs div+1 cycles later.
- Bad load: load_idx=25 -> load_err pulses for 1 cycle, code/idx/presc unchanged, and the step due that cycle is skipped.
